// File: rtl/lob_pkg.sv
// Shared definitions for the limit order book core and its host-side issuer.
package lob_pkg;

  // Core command codes; 6 and 7 are unassigned.
  localparam logic [2:0] TYPE_ADD             = 3'd0;
  localparam logic [2:0] TYPE_EXECUTE         = 3'd1;
  localparam logic [2:0] TYPE_CANCEL          = 3'd2;
  localparam logic [2:0] TYPE_DELETE          = 3'd3;
  localparam logic [2:0] TYPE_BEST_LIMIT      = 3'd4;
  localparam logic [2:0] TYPE_VOLUME_AT_LIMIT = 3'd5;

  // Response status byte values.
  localparam logic [7:0] STATUS_OK       = 8'h00;
  localparam logic [7:0] STATUS_BAD_TYPE = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT  = 8'h02;

  localparam int unsigned MSG_BYTES  = 7;
  localparam int unsigned RESP_BYTES = 3;

  typedef enum logic [2:0] {
    StCollect,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StRespond
  } state_e;

  function automatic logic is_valid_type(input logic [2:0] t);
    return t <= TYPE_VOLUME_AT_LIMIT;
  endfunction

endpackage

// File: rtl/lob_msg_assembler.sv
// Byte index counter and command field registers for inbound 7-byte order messages.
module lob_msg_assembler
  import lob_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_data,
  input  logic        i_fire,
  output logic [2:0]  o_type,
  output logic        o_side,
  output logic [15:0] o_id,
  output logic [15:0] o_size,
  output logic [15:0] o_limit,
  output logic        o_msg_complete
);

  localparam int unsigned IdxW = $clog2(MSG_BYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MSG_BYTES - 1);

  logic [IdxW-1:0] r_idx;
  logic [2:0]      r_type;
  logic            r_side;
  logic [15:0]     r_id;
  logic [15:0]     r_size;
  logic [15:0]     r_limit;

  // Pulses in the cycle the last byte is accepted so the FSM can act on it at once.
  assign o_msg_complete = i_fire && (r_idx == LastIdx);

  // Load the field addressed by the byte index on each accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_type  <= '0;
      r_side  <= 1'b0;
      r_id    <= '0;
      r_size  <= '0;
      r_limit <= '0;
    end else if (i_fire) begin
      r_idx <= o_msg_complete ? '0 : r_idx + 1'b1;
      case (r_idx)
        3'd0: begin
          r_side <= i_data[7];
          r_type <= i_data[2:0];
        end
        3'd1: r_id[15:8]    <= i_data;
        3'd2: r_id[7:0]     <= i_data;
        3'd3: r_size[15:8]  <= i_data;
        3'd4: r_size[7:0]   <= i_data;
        3'd5: r_limit[15:8] <= i_data;
        3'd6: r_limit[7:0]  <= i_data;
        default: ;
      endcase
    end
  end

  assign o_type  = r_type;
  assign o_side  = r_side;
  assign o_id    = r_id;
  assign o_size  = r_size;
  assign o_limit = r_limit;

endmodule

// File: rtl/lob_message_issuer.sv
// Host-side initiator: assembles order messages, issues them to the order book core over
// start/busy, and streams back a 3-byte status/result response.
module lob_message_issuer
  import lob_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             lob_start,
  output logic [2:0]       lob_type,
  output logic             lob_side,
  output logic [15:0]      lob_id,
  output logic [15:0]      lob_size,
  output logic [15:0]      lob_limit,
  input  logic [15:0]      lob_out,
  input  logic             lob_busy,
  output logic [CNT_W-1:0] msg_count
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RespLast = 2'(RESP_BYTES - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [TimerW-1:0] r_timer;
  logic [7:0]        r_status;
  logic [15:0]       r_result;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic [1:0]        r_resp_idx;
  logic [CNT_W-1:0]  r_msg_count;

  logic w_rx_fire;
  logic w_tx_fire;
  logic w_msg_complete;
  logic w_timeout;
  logic w_last_resp;
  logic [2:0] w_type;

  assign rx_ready    = (r_state == StCollect);
  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_tx_fire   = r_tx_valid && tx_ready;
  assign w_timeout   = (r_timer == TimerLast);
  assign w_last_resp = (r_resp_idx == RespLast);
  // Start only into an idle core, so a core left hung by a timeout is never restarted.
  assign lob_start   = (r_state == StIssue) && !lob_busy;

  lob_msg_assembler u_assembler (
    .clk            (clk),
    .rst            (rst),
    .i_data         (rx_data),
    .i_fire         (w_rx_fire),
    .o_type         (w_type),
    .o_side         (lob_side),
    .o_id           (lob_id),
    .o_size         (lob_size),
    .o_limit        (lob_limit),
    .o_msg_complete (w_msg_complete)
  );

  assign lob_type = w_type;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StCollect;
    else      r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StCollect: begin
        if (w_msg_complete) w_state_next = is_valid_type(w_type) ? StIssue : StRespond;
      end
      StIssue: begin
        if (!lob_busy) w_state_next = StWaitBusy;
      end
      StWaitBusy: begin
        if (w_timeout)     w_state_next = StRespond;
        else if (lob_busy) w_state_next = StWaitDone;
      end
      StWaitDone: begin
        if (!lob_busy || w_timeout) w_state_next = StRespond;
      end
      StRespond: begin
        if (w_tx_fire && w_last_resp) w_state_next = StCollect;
      end
      default: w_state_next = StCollect;
    endcase
  end

  // Timer, result capture, response serializer and transaction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer     <= '0;
      r_status    <= STATUS_OK;
      r_result    <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_resp_idx  <= '0;
      r_msg_count <= '0;
    end else begin
      if (r_state == StIssue) begin
        r_timer <= '0;
      end else if (r_state == StWaitBusy || r_state == StWaitDone) begin
        r_timer <= r_timer + 1'b1;
      end

      // Status is fixed by the state that hands over to RESPOND.
      if (w_state_next == StRespond && r_state != StRespond) begin
        if (r_state == StCollect) begin
          r_status <= STATUS_BAD_TYPE;
          r_result <= '0;
        end else if (r_state == StWaitDone && !lob_busy) begin
          r_status <= STATUS_OK;
          r_result <= lob_out;
        end else begin
          r_status <= STATUS_TIMEOUT;
          r_result <= '0;
        end
      end

      if (r_state == StRespond) begin
        if (!r_tx_valid) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= r_status;
          r_resp_idx <= '0;
        end else if (tx_ready) begin
          if (w_last_resp) begin
            r_tx_valid  <= 1'b0;
            r_resp_idx  <= '0;
            r_msg_count <= r_msg_count + 1'b1;
          end else begin
            r_resp_idx <= r_resp_idx + 1'b1;
            r_tx_data  <= (r_resp_idx == 2'd0) ? r_result[15:8] : r_result[7:0];
          end
        end
      end
    end
  end

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign msg_count = r_msg_count;

endmodule

// File: tb/tb_lob_message_issuer.sv
// Directed bench for lob_message_issuer with a small behavioural order book core.
module tb_lob_message_issuer;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          lob_start;
  logic [2:0]    lob_type;
  logic          lob_side;
  logic [15:0]   lob_id;
  logic [15:0]   lob_size;
  logic [15:0]   lob_limit;
  logic [15:0]   lob_out;
  logic          lob_busy;
  logic [CW-1:0] msg_count;

  int checks = 0;
  int errors = 0;
  int start_count = 0;

  // Core model controls.
  logic        hung;
  logic        force_busy;
  logic [15:0] model_result;
  logic        m_busy;
  logic        m_active;
  logic [2:0]  m_cnt;
  logic [15:0] m_out;

  lob_message_issuer #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .lob_start (lob_start),
    .lob_type  (lob_type),
    .lob_side  (lob_side),
    .lob_id    (lob_id),
    .lob_size  (lob_size),
    .lob_limit (lob_limit),
    .lob_out   (lob_out),
    .lob_busy  (lob_busy),
    .msg_count (msg_count)
  );

  always #5 clk = ~clk;

  assign lob_busy = m_busy | force_busy;
  assign lob_out  = m_out;

  // Core model: busy rises 2 cycles after the start edge, falls with out updated.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy   <= 1'b0;
      m_active <= 1'b0;
      m_cnt    <= '0;
      m_out    <= '0;
    end else if (lob_start && !hung && !m_active) begin
      m_active <= 1'b1;
      m_cnt    <= '0;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1'b1;
      if (m_cnt == 3'd1) m_busy <= 1'b1;
      if (m_cnt == 3'd4) begin
        m_busy   <= 1'b0;
        m_out    <= model_result;
        m_active <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (lob_start) start_count <= start_count + 1;
  end

  // Send the first n bytes of msg (B0 in the top byte); starts and ends on a negedge.
  task automatic send_bytes(input logic [55:0] msg, input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      rx_valid = 1'b1;
      rx_data  = msg[55-8*i -: 8];
      while (!rx_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!rx_ready) begin
        checks++; errors++;
        $display("FAIL rx_ready_wait: rx_ready=%b required 1", rx_ready);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  // Collect 3 response bytes; toggle makes tx_ready alternate 0/1.
  task automatic recv_resp(input bit toggle, output logic [23:0] resp, output int got,
                           output bit unstable, output bit rx_seen);
    int cyc;
    bit stalled;
    logic [7:0] held;
    cyc = 0; got = 0; stalled = 1'b0; held = '0;
    unstable = 1'b0; rx_seen = 1'b0; resp = '0;
    while (got < 3 && cyc < 300) begin
      tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (stalled && tx_valid && tx_data !== held) unstable = 1'b1;
      if (rx_ready !== 1'b0) rx_seen = 1'b1;
      stalled = 1'b0;
      if (tx_valid && tx_ready) begin
        resp = {resp[15:0], tx_data};
        got++;
      end else if (tx_valid) begin
        stalled = 1'b1;
        held = tx_data;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b required 1", rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
    checks++; if (lob_start !== 1'b0) begin errors++; $display("FAIL reset_lob_start: got %b required 0", lob_start); end
    checks++;
    if ({lob_type, lob_side, lob_id, lob_size, lob_limit} !== 52'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h required 0", {lob_type, lob_side, lob_id, lob_size, lob_limit});
    end
    checks++; if (msg_count !== 3'd0) begin errors++; $display("FAIL reset_msg_count: got %0d required 0", msg_count); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Issue a valid message, check the start-cycle fields, then the response and counter.
  task automatic run_valid(input string name, input logic [55:0] msg, input logic [15:0] res,
                           input logic [51:0] fields, input logic [CW-1:0] cnt);
    logic [23:0] resp; int got; bit uns; bit rxs; int s0;
    s0 = start_count;
    model_result = res;
    send_bytes(msg, 7);
    checks++; if (lob_start !== 1'b1) begin errors++; $display("FAIL %s_start: got %b required 1", name, lob_start); end
    checks++;
    if ({lob_type, lob_side, lob_id, lob_size, lob_limit} !== fields) begin
      errors++;
      $display("FAIL %s_fields: got %h required %h", name,
               {lob_type, lob_side, lob_id, lob_size, lob_limit}, fields);
    end
    recv_resp(1'b0, resp, got, uns, rxs);
    checks++; if (resp !== {8'h00, res} || got != 3) begin errors++; $display("FAIL %s_resp: got %h (%0d bytes) required %h", name, resp, got, {8'h00, res}); end
    checks++; if (msg_count !== cnt) begin errors++; $display("FAIL %s_count: got %0d required %0d", name, msg_count, cnt); end
    checks++; if (start_count - s0 != 1) begin errors++; $display("FAIL %s_starts: got %0d required 1", name, start_count - s0); end
  endtask

  task automatic test_add_bid;
    run_valid("add_bid", 56'h00_002A_0064_03E8, 16'h002A,
              {3'd0, 1'b0, 16'h002A, 16'd100, 16'd1000}, 3'd1);
  endtask

  task automatic test_best_limit;
    run_valid("best_limit", 56'h84_0000_0000_0000, 16'h03E8,
              {3'd4, 1'b1, 16'h0000, 16'h0000, 16'h0000}, 3'd2);
  endtask

  task automatic test_bad_type(input logic [CW-1:0] cnt);
    logic [23:0] resp; int got; bit uns; bit rxs; int s0;
    s0 = start_count;
    send_bytes(56'h07_1111_2222_3333, 7);
    checks++; if (lob_start !== 1'b0) begin errors++; $display("FAIL bad_type_start: got %b required 0", lob_start); end
    recv_resp(1'b0, resp, got, uns, rxs);
    checks++; if (resp !== 24'h010000 || got != 3) begin errors++; $display("FAIL bad_type_resp: got %h required 010000", resp); end
    checks++; if (start_count != s0) begin errors++; $display("FAIL bad_type_starts: got %0d required 0", start_count - s0); end
    checks++; if (msg_count !== cnt) begin errors++; $display("FAIL bad_type_count: got %0d required %0d", msg_count, cnt); end
  endtask

  task automatic test_timeout;
    logic [23:0] resp; int got; bit uns; bit rxs; int n;
    hung = 1'b1;
    send_bytes(56'h00_0001_0002_0003, 7);
    checks++; if (lob_start !== 1'b1) begin errors++; $display("FAIL timeout_start: got %b required 1", lob_start); end
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 18) begin errors++; $display("FAIL timeout_latency: got %0d cycles required 18", n); end
    recv_resp(1'b0, resp, got, uns, rxs);
    checks++; if (resp !== 24'h020000 || got != 3) begin errors++; $display("FAIL timeout_resp: got %h required 020000", resp); end
    checks++; if (msg_count !== 3'd4) begin errors++; $display("FAIL timeout_count: got %0d required 4", msg_count); end
  endtask

  task automatic test_wait_idle;
    logic [23:0] resp; int got; bit uns; bit rxs; int s0;
    force_busy = 1'b1;
    hung = 1'b0;
    model_result = 16'h1234;
    s0 = start_count;
    send_bytes(56'h01_0005_0006_0007, 7);
    checks++; if (lob_start !== 1'b0) begin errors++; $display("FAIL busy_hold_start: got %b required 0", lob_start); end
    repeat (5) @(negedge clk);
    checks++; if (start_count != s0) begin errors++; $display("FAIL busy_hold_starts: got %0d required 0", start_count - s0); end
    force_busy = 1'b0;
    #1;
    checks++; if (lob_start !== 1'b1 || lob_type !== 3'd1) begin errors++; $display("FAIL busy_release_start: got start=%b type=%0d required 1/1", lob_start, lob_type); end
    recv_resp(1'b0, resp, got, uns, rxs);
    checks++; if (resp !== 24'h001234 || got != 3) begin errors++; $display("FAIL busy_release_resp: got %h required 001234", resp); end
    checks++; if (msg_count !== 3'd5) begin errors++; $display("FAIL busy_release_count: got %0d required 5", msg_count); end
  endtask

  task automatic test_backpressure;
    logic [23:0] resp; int got; bit uns; bit rxs;
    model_result = 16'hBEEF;
    send_bytes(56'h80_0010_0020_0030, 7);
    recv_resp(1'b1, resp, got, uns, rxs);
    checks++; if (resp !== 24'h00BEEF || got != 3) begin errors++; $display("FAIL bp_resp: got %h required 00BEEF", resp); end
    checks++; if (uns) begin errors++; $display("FAIL bp_stable: tx_data changed while stalled, required stable"); end
    checks++; if (rxs) begin errors++; $display("FAIL bp_rx_ready: rx_ready seen 1 before R2 accepted, required 0"); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL bp_rx_ready_after: got %b required 1", rx_ready); end
    checks++; if (msg_count !== 3'd6) begin errors++; $display("FAIL bp_count: got %0d required 6", msg_count); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    send_bytes(56'h00_00AA_00BB_00CC, 4);
    rst = 1'b0;
    #1;
    checks++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || lob_start !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got rx_ready=%b tx_valid=%b start=%b required 1/0/0", rx_ready, tx_valid, lob_start); end
    checks++; if (msg_count !== 3'd0) begin errors++; $display("FAIL midreset_count: got %0d required 0", msg_count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_valid("after_reset", 56'h05_0102_0304_0506, 16'h5555,
              {3'd5, 1'b0, 16'h0102, 16'h0304, 16'h0506}, 3'd1);
    tx_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    tx_ready = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL after_reset_extra: extra response byte seen, required none"); end
  endtask

  initial begin
    rst = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    hung = 1'b0;
    force_busy = 1'b0;
    model_result = '0;
    @(negedge clk);
    test_reset;
    test_add_bid;
    test_best_limit;
    test_bad_type(3'd3);
    test_timeout;
    test_wait_idle;
    test_backpressure;
    test_bad_type(3'd7);
    test_bad_type(3'd0);
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lob_message_issuer.md
# lob_message_issuer

Host-side initiator for the limit order book core. Accepts a byte stream of 7-byte order messages, decodes them into the core's parallel command fields, and issues each one over the core's start/busy handshake. Captures the 16-bit result when busy falls and returns a 3-byte response stream. Sits between the host byte link (UART/PCIe shim) and the order book core.

## Interface
- TIMEOUT_CYCLES, 1024, max cycles from start pulse to busy falling before status TIMEOUT is reported
- CNT_W, 16, width of msg_count
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- rx_data  input  8  inbound message byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  issuer accepts a byte this cycle (rx_valid & rx_ready)
- tx_data  output  8  outbound response byte
- tx_valid  output  1  tx_data valid; held with data stable until accepted
- tx_ready  input  1  host accepts tx byte
- lob_start  output  1  one-cycle command pulse to the core
- lob_type  output  3  command code (0 add, 1 execute, 2 cancel, 3 delete, 4 best limit, 5 volume at limit)
- lob_side  output  1  0 bid, 1 ask
- lob_id, lob_size, lob_limit  output  16 each  command fields
- lob_out  input  16  core result, valid when lob_busy falls
- lob_busy  input  1  core busy flag
- msg_count  output  CNT_W  completed transactions (any status), wraps

## Operation
- Message bytes, in order: B0 = {side[7], reserved[6:3], type[2:0]}; B1-B2 id, B3-B4 size, B5-B6 limit, each big-endian. Reserved bits ignored.
- Response bytes: R0 status (0x00 OK, 0x01 BAD_TYPE, 0x02 TIMEOUT), R1 = result[15:8], R2 = result[7:0]. Result is 0x0000 for any non-OK status.
- States:
  - COLLECT: rx_ready=1; byte index 0..6; field registers loaded on accept. After B6: type 6/7 -> RESPOND with BAD_TYPE, no core command; otherwise -> ISSUE.
  - ISSUE: wait while lob_busy=1. When lob_busy=0: lob_start=1 for exactly this cycle, clear timer -> WAIT_BUSY.
  - WAIT_BUSY: wait for lob_busy=1 -> WAIT_DONE.
  - WAIT_DONE: on lob_busy=0, capture lob_out into result, status OK -> RESPOND.
  - RESPOND: emit R0, R1, R2; after R2 is accepted, increment msg_count -> COLLECT.
- Timer runs in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES -> RESPOND with TIMEOUT. The next ISSUE still waits for lob_busy=0, so a hung core is never double-started.
- lob_type/side/id/size/limit are registered and held stable from the lob_start cycle until the issuer leaves WAIT_DONE. The core samples them several cycles after start.
- rx_ready=0 outside COLLECT: no pipelining of a second message.

## Timing
- Reset values: rx_ready=1 (decoded from state, COLLECT), tx_valid=0, tx_data=0, lob_start=0, all lob field outputs 0, msg_count=0, byte index 0, timer 0.
- The core raises busy 2 cycles after the start edge and drops it in the same cycle its out register updates. lob_out is therefore sampled on the first cycle lob_busy is seen low in WAIT_DONE.
- Best case, last rx byte to lob_start: 1 cycle when the core is idle.
- tx: tx_valid rises the cycle after entering RESPOND. One byte per cycle under continuous tx_ready. tx_data must not change while tx_valid=1 and tx_ready=0.
- Reset asserted mid-transaction: immediate return to COLLECT, any partial message discarded, lob_start deasserted, tx_valid dropped. No response is emitted for the interrupted message.
- msg_count wraps from 2^CNT_W-1 to 0.

## Structure
- Shared package lob_pkg: type codes (TYPE_ADD..TYPE_VOLUME_AT_LIMIT), status codes, MSG_BYTES=7, RESP_BYTES=3, state encoding.
- The core's type codes live only in lob_pkg, shared with the core.
- One sub-module, lob_msg_assembler: byte index counter plus field registers, with a msg_complete pulse. The FSM, timer and tx serializer stay in the top.

## Test plan
- Add bid: bytes 00 00 2A 00 64 03 E8 -> lob_start with type=0, side=0, id=0x002A, size=100, limit=1000. With the model core returning 0x002A -> response 00 00 2A, msg_count=1.
- Best limit ask: 84 00 00 00 00 00 00 -> type=4, side=1. Model returns 0x03E8 -> response 00 03 E8.
- Bad type: 07 followed by 6 bytes -> no lob_start, response 01 00 00.
- Hung core: model never raises busy, TIMEOUT_CYCLES=16 -> response 02 00 00 after 16 cycles. A following message waits for busy=0 before starting.
- Backpressure: tx_ready toggles 0/1 every cycle -> 3 bytes delivered in order, tx_data stable while stalled, rx_ready=0 until R2 is accepted.
- Reset after B3: assert rst, then send a full valid message -> exactly one lob_start with the new fields, and no response for the aborted message.
